// File: rtl/udp_ip_hdr_calc.sv
// UDP/IPv4 header length and checksum calculator with a registered payload pass-through.
// Define UDP_CHECKSUM_EN to compute the UDP checksum; otherwise it reports 0x0000.

module udp_ip_hdr_calc #(
  parameter int         DATA_WIDTH  = 8,
  parameter int         MAX_PAYLOAD = 1472,
  parameter logic [7:0] IP_TTL      = 8'd64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,
  input  logic [31:0]           cfg_src_ip,
  input  logic [31:0]           cfg_dst_ip,
  input  logic [15:0]           cfg_src_port,
  input  logic [15:0]           cfg_dst_port,
  input  logic [15:0]           cfg_ip_id,
  output logic                  m_hdr_tvalid,
  output logic                  m_hdr_tuser,
  input  logic                  m_hdr_trdy,
  output logic [15:0]           m_udp_hdr_length,
  output logic [15:0]           m_udp_hdr_checksum,
  output logic [15:0]           m_ip_hdr_length,
  output logic [15:0]           m_ip_hdr_checksum
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FOLD1,
    FOLD2,
    DONE
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [31:0]           src_ip_q;
  logic [31:0]           dst_ip_q;
  logic [15:0]           ip_id_q;
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;
  logic [31:0]           ip_sum_q;
  logic [31:0]           ip_sum_d;
  logic                  hdr_valid_q;
  logic                  hdr_err_q;
  logic [15:0]           udp_len_q;
  logic [15:0]           ip_len_q;
  logic [15:0]           ip_csum_q;
  logic [15:0]           udp_len_w;
  logic [15:0]           ip_len_w;
  logic                  in_accept;
  logic                  xfer;

  // One's-complement fold of a 32-bit sum with two end-around carries.
  function automatic logic [15:0] fold32(input logic [31:0] s);
    logic [16:0] t;
    t = {1'b0, s[31:16]} + {1'b0, s[15:0]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  assign in_accept = ((state_q == IDLE) || (state_q == ACCUM))
                   && (!m_valid_q || m_axis_trdy);
  assign s_axis_trdy = in_accept;
  assign xfer = s_axis_tvalid && in_accept;

  assign cnt_d = (state_q == IDLE) ? 16'd1
               : (&cnt_q)          ? cnt_q
               : cnt_q + 16'd1;

  assign udp_len_w = cnt_q + 16'd8;
  assign ip_len_w  = cnt_q + 16'd28;

  assign ip_sum_d = 32'h0000_4500
                  + {16'd0, ip_len_w}
                  + {16'd0, ip_id_q}
                  + 32'h0000_4000
                  + {16'd0, IP_TTL, 8'h11}
                  + {16'd0, src_ip_q[31:16]}
                  + {16'd0, src_ip_q[15:0]}
                  + {16'd0, dst_ip_q[31:16]}
                  + {16'd0, dst_ip_q[15:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      ip_id_q     <= '0;
      cnt_q       <= '0;
      ip_sum_q    <= '0;
      hdr_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      udp_len_q   <= '0;
      ip_len_q    <= '0;
      ip_csum_q   <= '0;
    end else begin
      if (xfer) begin
        m_data_q  <= s_axis_tdata;
        m_last_q  <= s_axis_tlast;
        m_valid_q <= 1'b1;
      end else if (m_axis_trdy) begin
        m_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            src_ip_q <= cfg_src_ip;
            dst_ip_q <= cfg_dst_ip;
            ip_id_q  <= cfg_ip_id;
            cnt_q    <= cnt_d;
            state_q  <= s_axis_tlast ? FOLD1 : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (s_axis_tlast) begin
              state_q <= FOLD1;
            end
          end
        end
        FOLD1: begin
          ip_sum_q <= ip_sum_d;
          state_q  <= FOLD2;
        end
        FOLD2: begin
          udp_len_q   <= udp_len_w;
          ip_len_q    <= ip_len_w;
          ip_csum_q   <= ~fold32(ip_sum_q);
          hdr_err_q   <= (cnt_q > MAX_LEN);
          hdr_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (m_hdr_trdy) begin
            hdr_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic        odd_q;
  logic        odd_w;
  logic [15:0] sport_q;
  logic [15:0] dport_q;
  logic [31:0] udp_sum_q;
  logic [31:0] udp_sum_d;
  logic [15:0] udp_csum_q;
  logic [15:0] udp_csum_d;
  logic [15:0] udp_res_w;
  logic [15:0] word_w;

  // Even-index bytes land in the high half; a lone last byte pads with 0x00.
  assign odd_w  = (state_q == ACCUM) && odd_q;
  assign word_w = odd_w ? {8'h00, s_axis_tdata} : {s_axis_tdata, 8'h00};
  assign acc_d  = ((state_q == IDLE) ? 32'd0 : acc_q) + {16'd0, word_w};

  assign udp_sum_d = {16'd0, acc_q[31:16]}
                   + {16'd0, acc_q[15:0]}
                   + {16'd0, src_ip_q[31:16]}
                   + {16'd0, src_ip_q[15:0]}
                   + {16'd0, dst_ip_q[31:16]}
                   + {16'd0, dst_ip_q[15:0]}
                   + 32'h0000_0011
                   + {16'd0, udp_len_w}
                   + {16'd0, udp_len_w}
                   + {16'd0, sport_q}
                   + {16'd0, dport_q};

  assign udp_res_w  = ~fold32(udp_sum_q);
  assign udp_csum_d = (udp_res_w == 16'h0000) ? 16'hFFFF : udp_res_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      odd_q      <= 1'b0;
      sport_q    <= '0;
      dport_q    <= '0;
      udp_sum_q  <= '0;
      udp_csum_q <= '0;
    end else begin
      if (xfer) begin
        acc_q <= acc_d;
        odd_q <= ~odd_w;
      end
      if (xfer && (state_q == IDLE)) begin
        sport_q <= cfg_src_port;
        dport_q <= cfg_dst_port;
      end
      if (state_q == FOLD1) begin
        udp_sum_q <= udp_sum_d;
      end
      if (state_q == FOLD2) begin
        udp_csum_q <= udp_csum_d;
      end
    end
  end

  assign m_udp_hdr_checksum = udp_csum_q;
`else
  logic unused_ports;
  assign unused_ports = ^{cfg_src_port, cfg_dst_port};
  assign m_udp_hdr_checksum = 16'h0000;
`endif

  assign m_axis_tdata     = m_data_q;
  assign m_axis_tvalid    = m_valid_q;
  assign m_axis_tlast     = m_last_q;
  assign m_hdr_tvalid     = hdr_valid_q;
  assign m_hdr_tuser      = hdr_err_q;
  assign m_udp_hdr_length = udp_len_q;
  assign m_ip_hdr_length  = ip_len_q;
  assign m_ip_hdr_checksum = ip_csum_q;

endmodule

// File: tb/tb_udp_ip_hdr_calc.sv
// Directed self-checking bench for udp_ip_hdr_calc.
// Expected UDP checksums fall back to 0x0000 unless UDP_CHECKSUM_EN is defined.

module tb_udp_ip_hdr_calc;

`ifdef UDP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_trdy;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_trdy;
  logic [31:0] cfg_src_ip;
  logic [31:0] cfg_dst_ip;
  logic [15:0] cfg_src_port;
  logic [15:0] cfg_dst_port;
  logic [15:0] cfg_ip_id;
  logic        m_hdr_tvalid;
  logic        m_hdr_tuser;
  logic        m_hdr_trdy;
  logic [15:0] m_udp_hdr_length;
  logic [15:0] m_udp_hdr_checksum;
  logic [15:0] m_ip_hdr_length;
  logic [15:0] m_ip_hdr_checksum;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] rx_d[$];
  logic       rx_l[$];

  always #4 clk = ~clk;

  udp_ip_hdr_calc dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_trdy        (s_axis_trdy),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_trdy        (m_axis_trdy),
    .cfg_src_ip         (cfg_src_ip),
    .cfg_dst_ip         (cfg_dst_ip),
    .cfg_src_port       (cfg_src_port),
    .cfg_dst_port       (cfg_dst_port),
    .cfg_ip_id          (cfg_ip_id),
    .m_hdr_tvalid       (m_hdr_tvalid),
    .m_hdr_tuser        (m_hdr_tuser),
    .m_hdr_trdy         (m_hdr_trdy),
    .m_udp_hdr_length   (m_udp_hdr_length),
    .m_udp_hdr_checksum (m_udp_hdr_checksum),
    .m_ip_hdr_length    (m_ip_hdr_length),
    .m_ip_hdr_checksum  (m_ip_hdr_checksum)
  );

  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_trdy) begin
      rx_d.push_back(m_axis_tdata);
      rx_l.push_back(m_axis_tlast);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ucs(input logic [15:0] v);
    return CSUM ? v : 16'h0000;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l,
                           input bit rnd);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    do begin
      if (rnd) m_axis_trdy = 1'($urandom_range(0, 1));
      #1;
      acc = s_axis_trdy;
      tick();
      n++;
    end while (!acc && n <= 200);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      n_asrt++;
      n_fail++;
      $error("FAIL accept_timeout: observed %0d cycles expected <= 200", n);
    end
  endtask

  task automatic send_pkt(input logic [7:0] pl[$], input bit rnd);
    for (int i = 0; i < pl.size(); i++) begin
      send_byte(pl[i], (i == pl.size() - 1), rnd);
    end
    m_axis_trdy = 1'b1;
  endtask

  task automatic wait_hdr(input string tag);
    int n;
    n = 0;
    while (!m_hdr_tvalid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_hdr_valid"}, m_hdr_tvalid, 1);
  endtask

  task automatic check_hdr(input string tag, input logic [15:0] ulen,
                           input logic [15:0] ilen, input logic [15:0] icsum,
                           input logic [15:0] ucsum, input logic err);
    chk({tag, "_udp_len"}, m_udp_hdr_length, ulen);
    chk({tag, "_ip_len"}, m_ip_hdr_length, ilen);
    chk({tag, "_ip_csum"}, m_ip_hdr_checksum, icsum);
    chk({tag, "_udp_csum"}, m_udp_hdr_checksum, ucsum);
    chk({tag, "_tuser"}, m_hdr_tuser, err);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] pl[$],
                              input bit per_byte);
    int n;
    repeat (4) tick();
    chk({tag, "_stream_len"}, rx_d.size(), pl.size());
    n = (rx_d.size() < pl.size()) ? rx_d.size() : pl.size();
    if (per_byte) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_byte%0d", tag, i), rx_d[i], pl[i]);
      end
    end
    if (n > 0) begin
      chk({tag, "_last"}, rx_l[n-1], (n == pl.size()));
    end
  endtask

  initial begin
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic [7:0] p4[$];
    logic [7:0] p5[$];
    int bad_rdy;
    int bad_stab;

    p1 = '{8'h01, 8'h02, 8'h03, 8'h04};
    p2 = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 100; i++) p4.push_back(8'(i));
    for (int i = 0; i < 1500; i++) p5.push_back(8'(i * 7));

    reset_n       = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_trdy   = 1'b1;
    m_hdr_trdy    = 1'b1;
    cfg_src_ip    = 32'hC0A8_010A;
    cfg_dst_ip    = 32'hC0A8_0114;
    cfg_src_port  = 16'h04D2;
    cfg_dst_port  = 16'h162E;
    cfg_ip_id     = 16'h0000;

    #20;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_hdr_valid", m_hdr_tvalid, 0);
    chk("rst_udp_len", m_udp_hdr_length, 0);
    chk("rst_ip_csum", m_ip_hdr_checksum, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // 4-byte packet with exact latency
    rx_d.delete(); rx_l.delete();
    send_pkt(p1, 1'b0);
    chk("t1_lat1", m_hdr_tvalid, 0);
    tick();
    chk("t1_lat2", m_hdr_tvalid, 0);
    tick();
    chk("t1_lat3", m_hdr_tvalid, 1);
    check_hdr("t1", 16'h000C, 16'h0020, 16'hB75E, ucs(16'h5D61), 1'b0);
    check_stream("t1", p1, 1'b1);

    // odd length
    rx_d.delete(); rx_l.delete();
    send_pkt(p2, 1'b0);
    wait_hdr("t2");
    check_hdr("t2", 16'h000B, 16'h001F, 16'hB75F, ucs(16'h5D67), 1'b0);
    check_stream("t2", p2, 1'b1);

    // results held under back-pressure, next packet blocked
    rx_d.delete(); rx_l.delete();
    m_hdr_trdy = 1'b0;
    send_pkt(p1, 1'b0);
    tick();
    tick();
    chk("t3_hdr_valid", m_hdr_tvalid, 1);
    s_axis_tdata  = 8'hAA;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    bad_rdy  = 0;
    bad_stab = 0;
    repeat (10) begin
      #1;
      if (s_axis_trdy !== 1'b0) bad_rdy++;
      if (m_hdr_tvalid !== 1'b1 || m_ip_hdr_checksum !== 16'hB75E
          || m_udp_hdr_length !== 16'h000C
          || m_udp_hdr_checksum !== ucs(16'h5D61)) bad_stab++;
      tick();
    end
    chk("t3_trdy_low", bad_rdy, 0);
    chk("t3_stable", bad_stab, 0);
    chk("t3_no_leak", rx_d.size(), 4);
    rx_d.delete(); rx_l.delete();
    m_hdr_trdy = 1'b1;
    send_pkt(p2, 1'b0);
    wait_hdr("t3b");
    check_hdr("t3b", 16'h000B, 16'h001F, 16'hB75F, ucs(16'h5D67), 1'b0);
    check_stream("t3b", p2, 1'b1);

    // random output back-pressure over 100 bytes
    rx_d.delete(); rx_l.delete();
    send_pkt(p4, 1'b1);
    wait_hdr("t4");
    check_hdr("t4", 16'h006C, 16'h0080, 16'hB6FE, ucs(16'hC4D9), 1'b0);
    check_stream("t4", p4, 1'b1);

    // oversize packet
    rx_d.delete(); rx_l.delete();
    send_pkt(p5, 1'b0);
    wait_hdr("t5");
    chk("t5_tuser", m_hdr_tuser, 1);
    chk("t5_udp_len", m_udp_hdr_length, 16'h05E4);
    chk("t5_ip_len", m_ip_hdr_length, 16'h05F8);
    chk("t5_ip_csum", m_ip_hdr_checksum, 16'hB186);
    check_stream("t5", p5, 1'b0);

    // reset in the middle of a packet
    for (int i = 0; i < 50; i++) send_byte(8'(i + 16), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6_m_valid", m_axis_tvalid, 0);
    chk("t6_m_data", m_axis_tdata, 0);
    chk("t6_hdr_valid", m_hdr_tvalid, 0);
    chk("t6_tuser", m_hdr_tuser, 0);
    chk("t6_udp_len", m_udp_hdr_length, 0);
    chk("t6_ip_len", m_ip_hdr_length, 0);
    chk("t6_ip_csum", m_ip_hdr_checksum, 0);
    chk("t6_udp_csum", m_udp_hdr_checksum, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    rx_d.delete(); rx_l.delete();
    send_pkt(p1, 1'b0);
    wait_hdr("t7");
    check_hdr("t7", 16'h000C, 16'h0020, 16'hB75E, ucs(16'h5D61), 1'b0);
    check_stream("t7", p1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_ip_hdr_calc.md
Name: udp_ip_hdr_calc

Overview:
Sits directly upstream of the Ethernet MAC TX path and produces the header-field values that the MAC consumes on its s_hdr_tvalid / s_udp_hdr_length / s_udp_hdr_checksum / s_ip_hdr_length / s_ip_hdr_checksum inputs. It forwards the payload byte stream unchanged through one register stage to the TX FIFO. While forwarding, it counts payload bytes and accumulates the one's-complement UDP checksum. At end of packet it emits UDP length, UDP checksum, IPv4 total length and IPv4 header checksum with a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, payload byte width; only 8 is supported.
MAX_PAYLOAD, 1472, largest legal UDP payload in bytes; larger packets are flagged as errors.
IP_TTL, 8'd64, TTL byte used in the IPv4 checksum.

Ports:
clk  in  1  125 MHz clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
s_axis_tdata  in  8  payload byte.
s_axis_tvalid  in  1  payload byte valid.
s_axis_tlast  in  1  last payload byte of the packet.
s_axis_trdy  out  1  block accepts the payload byte.
m_axis_tdata  out  8  forwarded payload byte (registered).
m_axis_tvalid  out  1  forwarded byte valid.
m_axis_tlast  out  1  forwarded last byte.
m_axis_trdy  in  1  TX FIFO ready.
cfg_src_ip  in  32  source IPv4 address.
cfg_dst_ip  in  32  destination IPv4 address.
cfg_src_port  in  16  UDP source port.
cfg_dst_port  in  16  UDP destination port.
cfg_ip_id  in  16  IPv4 identification field.
m_hdr_tvalid  out  1  header results valid.
m_hdr_tuser  out  1  error: packet exceeded MAX_PAYLOAD.
m_hdr_trdy  in  1  consumer accepts the results.
m_udp_hdr_length  out  16  payload bytes + 8.
m_udp_hdr_checksum  out  16  UDP checksum.
m_ip_hdr_length  out  16  payload bytes + 28.
m_ip_hdr_checksum  out  16  IPv4 header checksum.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, and the counters and accumulators clear. Reset asserted mid-packet discards that packet entirely.
- Handshakes:
  - A transfer occurs on a cycle where valid and ready are both high.
  - s_axis_trdy = (state is IDLE or ACCUM) and (!m_axis_tvalid or m_axis_trdy).
  - The m_axis register loads on each s_axis transfer and clears its valid when m_axis_trdy=1 with no new transfer.
  - m_axis data and last are held while valid=1 and ready=0.
- FSM states:
  - IDLE: on the first byte transfer, sample all cfg_* fields into registers, start the byte count at 1, and go to ACCUM. If that byte has tlast=1, go to FOLD1 instead.
  - ACCUM: accumulate each transfer; on a transfer with tlast=1, go to FOLD1.
  - FOLD1: fold the accumulator, add the length and pseudo-header terms, and compute the IP header sum. Lasts one cycle.
  - FOLD2: final end-around carry and complement; register all results. Lasts one cycle.
  - DONE: m_hdr_tvalid=1 with all results held stable until m_hdr_trdy=1, then go to IDLE.
  - s_axis_trdy=0 in FOLD1, FOLD2 and DONE, so the next packet is back-pressured until the results are consumed.
- Latency: m_hdr_tvalid rises exactly 3 cycles after the tlast transfer cycle.
- Byte count: 16 bits and saturating.
  - If the count exceeds MAX_PAYLOAD, m_hdr_tuser=1 for that packet.
  - The lengths then report the saturated count + 8 and + 28, and the checksums are still produced.
- Payload accumulation:
  - Even-index bytes are the high byte of a 16-bit word; odd-index bytes are the low byte.
  - An odd-length packet pads its final word with 0x00 in the low byte.
  - The accumulator is 32 bits; it is folded to 16 bits with end-around carry twice.
- UDP sum terms: src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 0x0011, udp_len (counted twice: pseudo-header and UDP header), src_port, dst_port, and the payload words. Result = ~fold(sum). A computed result of 0x0000 is output as 0xFFFF.
- IP sum terms: 0x4500, ip_len, ip_id, 0x4000, {IP_TTL, 8'h11}, and the four IP address words. Result = ~fold(sum).
- Zero-length packets cannot occur: a packet always carries at least one byte.

Optional Feature:
UDP_CHECKSUM_EN
- Defined: the UDP checksum is computed as described above.
- Undefined: the payload accumulator and UDP sum logic are removed and m_udp_hdr_checksum is constant 0x0000 (checksum disabled, legal for IPv4). Lengths, IP checksum, FSM timing and latency are unchanged.

Test Plan:
- Common configuration for the first three tests: cfg_src_ip=C0A8010A, cfg_dst_ip=C0A80114, cfg_src_port=04D2, cfg_dst_port=162E, cfg_ip_id=0000, IP_TTL=64, m_axis_trdy=1, m_hdr_trdy=1.
- Payload 01 02 03 04 -> m_hdr_tvalid 3 cycles after tlast; udp_len=000C, ip_len=0020, ip_csum=B75E, udp_csum=5D61 (0000 with macro undefined); m_axis stream equals the input stream.
- Payload 01 02 03 (odd length) -> udp_len=000B, ip_len=001F; the final payload word is 0300; checksums match the reference model.
- Hold m_hdr_trdy=0 for 10 cycles after results, while a second packet is presented -> results stay stable and s_axis_trdy=0 throughout; the second packet is accepted only after the DONE handshake.
- Toggle m_axis_trdy randomly during a 100-byte packet -> no bytes lost or duplicated; udp_len=006C, ip_len=0080.
- 1500-byte packet with MAX_PAYLOAD=1472 -> m_hdr_tuser=1; deassert reset_n mid-packet on the next packet -> all outputs 0 and the next full packet computes correctly.
